// File: rtl/bcd_to_7_segment.sv
// Registered BCD to 7-segment decoder with lamp test, blanking and selectable polarity.
// Define BCD_TO_7_SEGMENT_HEX_EN to decode codes 10-15 as hex glyphs instead of a dash.
module bcd_to_7_segment #(
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] bcd,
  input  logic       bcd_valid,
  input  logic       lamp_test,
  input  logic       blank,
  output logic [6:0] segment,
  output logic       segment_valid,
  output logic       invalid
);

  localparam logic [6:0] ALL_ON  = 7'h7F;
  localparam logic [6:0] ALL_OFF = 7'h00;
  localparam logic [6:0] DASH    = 7'h40;

  logic [3:0] digit_q, digit_d;
  logic [6:0] segment_q, segment_d;
  logic       segment_valid_q, segment_valid_d;
  logic       invalid_q, invalid_d;
  logic [6:0] glyph;
  logic [6:0] logical;

  always_comb begin
    // A new digit is captured even while lamp test or blank hides it.
    digit_d = bcd_valid ? bcd : digit_q;

    glyph     = DASH;
    invalid_d = 1'b0;
    case (digit_d)
      4'd0: glyph = 7'h3F;
      4'd1: glyph = 7'h06;
      4'd2: glyph = 7'h5B;
      4'd3: glyph = 7'h4F;
      4'd4: glyph = 7'h66;
      4'd5: glyph = 7'h6D;
      4'd6: glyph = 7'h7D;
      4'd7: glyph = 7'h07;
      4'd8: glyph = 7'h7F;
      4'd9: glyph = 7'h6F;
`ifdef BCD_TO_7_SEGMENT_HEX_EN
      4'd10: glyph = 7'h77;
      4'd11: glyph = 7'h7C;
      4'd12: glyph = 7'h39;
      4'd13: glyph = 7'h5E;
      4'd14: glyph = 7'h79;
      4'd15: glyph = 7'h71;
`else
      default: begin
        glyph     = DASH;
        invalid_d = 1'b1;
      end
`endif
    endcase

    if (lamp_test) begin
      logical         = ALL_ON;
      segment_valid_d = 1'b0;
    end else if (blank) begin
      logical         = ALL_OFF;
      segment_valid_d = 1'b0;
    end else begin
      logical         = glyph;
      segment_valid_d = 1'b1;
    end

    // Polarity is applied last so priority is always decided on logical patterns.
    segment_d = ACTIVE_LOW ? ~logical : logical;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      digit_q         <= 4'd0;
      segment_q       <= ACTIVE_LOW ? ~ALL_OFF : ALL_OFF;
      segment_valid_q <= 1'b0;
      invalid_q       <= 1'b0;
    end else begin
      digit_q         <= digit_d;
      segment_q       <= segment_d;
      segment_valid_q <= segment_valid_d;
      invalid_q       <= invalid_d;
    end
  end

  assign segment       = segment_q;
  assign segment_valid = segment_valid_q;
  assign invalid       = invalid_q;

endmodule

// File: tb/tb_bcd_to_7_segment.sv
// Bench for bcd_to_7_segment: active-high and active-low instances driven in lockstep.
module tb_bcd_to_7_segment;

`ifdef BCD_TO_7_SEGMENT_HEX_EN
  localparam bit HEX = 1'b1;
`else
  localparam bit HEX = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset, bcd_valid, lamp_test, blank;
  logic [3:0] bcd;
  logic [6:0] seg_hi, seg_lo;
  logic       sv_hi, sv_lo, inv_hi, inv_lo;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  logic [6:0] tab [16];
  int         m_digit;
  logic [6:0] m_seg;
  logic       m_sv, m_inv;

  always #5 clock = ~clock;

  bcd_to_7_segment #(.ACTIVE_LOW(1'b0)) u_hi (
    .clock(clock), .reset(reset), .bcd(bcd), .bcd_valid(bcd_valid),
    .lamp_test(lamp_test), .blank(blank),
    .segment(seg_hi), .segment_valid(sv_hi), .invalid(inv_hi)
  );

  bcd_to_7_segment #(.ACTIVE_LOW(1'b1)) u_lo (
    .clock(clock), .reset(reset), .bcd(bcd), .bcd_valid(bcd_valid),
    .lamp_test(lamp_test), .blank(blank),
    .segment(seg_lo), .segment_valid(sv_lo), .invalid(inv_lo)
  );

  logic [17:0] obs;
  assign obs = {seg_hi, sv_hi, inv_hi, seg_lo, sv_lo, inv_lo};

  function automatic logic [17:0] px(input logic [6:0] e, input logic sv, input logic inv);
    return {e, sv, inv, ~e, sv, inv};
  endfunction

  // Drive one edge's inputs, advance the model, clock, then settle past the edge.
  task automatic cyc(input logic r, input logic v, input logic [3:0] b,
                     input logic lt, input logic bl);
    reset = r; bcd_valid = v; bcd = b; lamp_test = lt; blank = bl;
    if (r) begin
      m_digit = 0; m_seg = 7'h00; m_sv = 1'b0; m_inv = 1'b0;
    end else begin
      if (v) m_digit = int'(b);
      m_inv = !HEX && (m_digit > 9);
      if (lt)      begin m_seg = 7'h7F;         m_sv = 1'b0; end
      else if (bl) begin m_seg = 7'h00;         m_sv = 1'b0; end
      else         begin m_seg = tab[m_digit];  m_sv = 1'b1; end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    logic [17:0] e;
    cyc(1, 1, 4'd8, 1, 0);
    cyc(1, 0, 4'd0, 0, 0);
    e = px(7'h00, 0, 0); n_vec++;
    if (obs !== e) begin n_err++; $display("FAIL reset_held: got %h expected %h", obs, e); end
    cyc(0, 0, 4'd0, 0, 0);
    e = px(7'h3F, 1, 0); n_vec++;
    if (obs !== e) begin n_err++; $display("FAIL reset_release: got %h expected %h", obs, e); end
  endtask

  task automatic test_decode;
    logic [6:0] want [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    logic [17:0] e;
    cyc(0, 1, 4'd1, 0, 0);
    e = px(7'h06, 1, 0); n_vec++;
    if (obs !== e) begin n_err++; $display("FAIL decode_1: got %h expected %h", obs, e); end
    cyc(0, 1, 4'd6, 0, 0);
    e = px(7'h7D, 1, 0); n_vec++;
    if (obs !== e) begin n_err++; $display("FAIL decode_6: got %h expected %h", obs, e); end
    for (int d = 0; d < 10; d++) begin
      cyc(0, 1, 4'(d), 0, 0);
      e = px(want[d], 1, 0); n_vec++;
      if (obs !== e) begin n_err++; $display("FAIL sweep_%0d: got %h expected %h", d, obs, e); end
    end
  endtask

  task automatic test_invalid;
    logic [6:0] hexg [6] = '{7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    logic [17:0] e;
    cyc(0, 1, 4'd12, 0, 0);
    e = HEX ? px(7'h39, 1, 0) : px(7'h40, 1, 1); n_vec++;
    if (obs !== e) begin n_err++; $display("FAIL code_12: got %h expected %h", obs, e); end
    for (int d = 10; d < 16; d++) begin
      cyc(0, 1, 4'(d), 0, 0);
      e = HEX ? px(hexg[d-10], 1, 0) : px(7'h40, 1, 1); n_vec++;
      if (obs !== e) begin n_err++; $display("FAIL code_%0d: got %h expected %h", d, obs, e); end
    end
    // Lamp test must not clear the invalid flag of the held code.
    cyc(0, 0, 4'd0, 1, 0);
    e = px(7'h7F, 0, !HEX); n_vec++;
    if (obs !== e) begin n_err++; $display("FAIL invalid_under_lamp: got %h expected %h", obs, e); end
  endtask

  task automatic test_priority;
    logic [17:0] e;
    cyc(0, 1, 4'd3, 0, 0);
    e = px(7'h4F, 1, 0); n_vec++;
    if (obs !== e) begin n_err++; $display("FAIL held_3: got %h expected %h", obs, e); end
    cyc(0, 0, 4'd0, 1, 0);
    e = px(7'h7F, 0, 0); n_vec++;
    if (obs !== e) begin n_err++; $display("FAIL lamp: got %h expected %h", obs, e); end
    cyc(0, 0, 4'd0, 1, 1);
    e = px(7'h7F, 0, 0); n_vec++;
    if (obs !== e) begin n_err++; $display("FAIL lamp_over_blank: got %h expected %h", obs, e); end
    cyc(0, 0, 4'd0, 0, 1);
    e = px(7'h00, 0, 0); n_vec++;
    if (obs !== e) begin n_err++; $display("FAIL blank: got %h expected %h", obs, e); end
    cyc(0, 0, 4'd0, 0, 0);
    e = px(7'h4F, 1, 0); n_vec++;
    if (obs !== e) begin n_err++; $display("FAIL restore_3: got %h expected %h", obs, e); end
  endtask

  task automatic test_hold;
    logic [17:0] e;
    cyc(0, 1, 4'd5, 0, 0);
    cyc(0, 0, 4'd2, 0, 0);
    e = px(7'h6D, 1, 0); n_vec++;
    if (obs !== e) begin n_err++; $display("FAIL hold_5: got %h expected %h", obs, e); end
    // Digit captured while blanked shows up once blank drops.
    cyc(0, 1, 4'd7, 0, 1);
    cyc(0, 0, 4'd1, 0, 0);
    e = px(7'h07, 1, 0); n_vec++;
    if (obs !== e) begin n_err++; $display("FAIL capture_under_blank: got %h expected %h", obs, e); end
  endtask

  task automatic test_reset_mid;
    logic [17:0] e;
    cyc(0, 1, 4'd8, 0, 0);
    e = px(7'h7F, 1, 0); n_vec++;
    if (obs !== e) begin n_err++; $display("FAIL active_low_8: got %h expected %h", obs, e); end
    cyc(1, 1, 4'd9, 1, 1);
    e = px(7'h00, 0, 0); n_vec++;
    if (obs !== e) begin n_err++; $display("FAIL reset_override: got %h expected %h", obs, e); end
    cyc(0, 0, 4'd9, 0, 0);
    e = px(7'h3F, 1, 0); n_vec++;
    if (obs !== e) begin n_err++; $display("FAIL reset_discards: got %h expected %h", obs, e); end
  endtask

  task automatic test_random;
    logic r, v, lt, bl;
    logic [3:0] b;
    logic [17:0] e;
    for (int i = 0; i < 400; i++) begin
      r  = ($urandom_range(0, 19) == 0);
      v  = $urandom_range(0, 1) == 1;
      b  = 4'($urandom);
      lt = ($urandom_range(0, 6) == 0);
      bl = ($urandom_range(0, 5) == 0);
      cyc(r, v, b, lt, bl);
      e = px(m_seg, m_sv, m_inv); n_vec++;
      if (obs !== e) begin n_err++; $display("FAIL random_%0d: got %h expected %h", i, obs, e); end
    end
  endtask

  initial begin
    tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F,
            7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
    if (HEX) begin
      tab[10] = 7'h77; tab[11] = 7'h7C; tab[12] = 7'h39;
      tab[13] = 7'h5E; tab[14] = 7'h79; tab[15] = 7'h71;
    end
    m_digit = 0; m_seg = 7'h00; m_sv = 1'b0; m_inv = 1'b0;
    reset = 1'b1; bcd_valid = 1'b0; bcd = 4'd0; lamp_test = 1'b0; blank = 1'b0;
    #2;
    test_reset;
    test_decode;
    test_invalid;
    test_priority;
    test_hold;
    test_reset_mid;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
